mesh_unloader: RTL and testbench

Streams the finished subdivided mesh from the result RAM to an external consumer over a valid/ready word stream. It sits directly downstream of the subdivision top level. The controller pulses `start` once that block's `busy` has fallen, then this block takes ownership of the result RAM port. It reads the mesh header, computes the payload length, and emits every word in address order. A read pipeline absorbs backpressure with no lost or duplicated words.

---
 rtl/mesh_unloader.sv | 195 +++++++++++++++++++
 tb/tb_mesh_unloader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesh_unloader.sv
// Streams the subdivided mesh (header, vertices, faces) out of the result RAM
// over a valid/ready word stream, with a 2-entry read buffer for backpressure.
module mesh_unloader #(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           ram_do,
    output logic                  ram_en,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic [3:0]            ram_we,
    output logic [31:0]           ram_di,
    output logic [31:0]           out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  err,
    output logic [2:0]            dbg_state
);

    // Stream handshake: a word moves when out_valid && out_ready on a rising
    // edge; once raised, out_valid/out_data/out_last hold until that transfer.

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [34:0] CAPACITY = 35'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR    = 3'd1,
        S_CHECK  = 3'd2,
        S_STREAM = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic                  hdr_phase_q;
    logic [31:0]           v_q;
    logic [PW-1:0]         t_q;
    logic [PW-1:0]         rd_ptr_q;
    logic [PW-1:0]         last_addr;
    logic [ADDR_WIDTH-1:0] ram_a_q;
    logic                  inflight_q, inflight_last_q;
    logic [31:0]           fifo_d0, fifo_d1;
    logic                  fifo_l0, fifo_l1;
    logic [1:0]            fifo_cnt;
    logic                  err_q;

    logic                  issue, issue_last;
    logic [ADDR_WIDTH-1:0] issue_addr;
    logic                  push, push_last, pop, flush, err_d;
    logic [2:0]            occupancy;
    logic                  credit_ok;
    logic [34:0]           t_calc;
    logic                  overflow;

    // Wide enough that no pair of 32-bit header values can wrap.
    assign t_calc    = 35'd2 + (35'(v_q) * 35'd3) + (35'(ram_do) << 2);
    assign overflow  = t_calc > CAPACITY;
    assign last_addr = t_q - PW'(1);

    assign out_valid = ((state_q == S_STREAM) || (state_q == S_DRAIN)) && (fifo_cnt != 2'd0);
    assign out_data  = fifo_d0;
    assign out_last  = out_valid && fifo_l0;
    assign pop       = out_valid && out_ready;
    assign occupancy = {1'b0, fifo_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    assign credit_ok = occupancy < 3'd2;

    assign busy      = (state_q != S_IDLE);
    assign err       = err_q;
    assign ram_en    = issue;
    assign ram_a     = issue ? issue_addr : ram_a_q;
    assign ram_we    = 4'b0000;
    assign ram_di    = 32'd0;
    assign dbg_state = state_q;

    always_comb begin
        state_d    = state_q;
        issue      = 1'b0;
        issue_addr = ram_a_q;
        issue_last = 1'b0;
        push       = inflight_q;
        push_last  = inflight_last_q;
        flush      = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_HDR;
            end
            S_HDR: begin
                issue      = 1'b1;
                issue_addr = hdr_phase_q ? ADDR_WIDTH'(1) : '0;
                if (hdr_phase_q) state_d = S_CHECK;
            end
            S_CHECK: begin
                // Word 1 lands this cycle; it is the last word only for an empty mesh.
                push_last = (t_calc == 35'd2);
                if (overflow) begin
                    flush   = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (t_calc == 35'd2) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (credit_ok) begin
                    issue      = 1'b1;
                    issue_addr = rd_ptr_q[ADDR_WIDTH-1:0];
                    issue_last = (rd_ptr_q == last_addr);
                    if (issue_last) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!inflight_q && ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop)))
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_IDLE;
            hdr_phase_q     <= 1'b0;
            v_q             <= '0;
            t_q             <= '0;
            rd_ptr_q        <= '0;
            ram_a_q         <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_d0         <= '0;
            fifo_d1         <= '0;
            fifo_l0         <= 1'b0;
            fifo_l1         <= 1'b0;
            fifo_cnt        <= '0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            err_q           <= err_d;
            inflight_q      <= issue;
            inflight_last_q <= issue_last;
            if (issue) ram_a_q <= issue_addr;
            if (state_q == S_IDLE) hdr_phase_q <= 1'b0;
            if (state_q == S_HDR) begin
                hdr_phase_q <= 1'b1;
                if (hdr_phase_q) v_q <= ram_do;
            end
            if ((state_q == S_CHECK) && !overflow) begin
                t_q      <= t_calc[PW-1:0];
                rd_ptr_q <= PW'(2);
            end
            if (issue && (state_q == S_STREAM)) rd_ptr_q <= rd_ptr_q + PW'(1);

            // Head lives in entry 0; the credit rule keeps a push off a full buffer.
            if (flush) begin
                fifo_cnt <= 2'd0;
            end else begin
                case ({push, pop})
                    2'b10: begin
                        if (fifo_cnt == 2'd0) begin
                            fifo_d0 <= ram_do;
                            fifo_l0 <= push_last;
                        end else begin
                            fifo_d1 <= ram_do;
                            fifo_l1 <= push_last;
                        end
                        fifo_cnt <= fifo_cnt + 2'd1;
                    end
                    2'b01: begin
                        fifo_d0  <= fifo_d1;
                        fifo_l0  <= fifo_l1;
                        fifo_cnt <= fifo_cnt - 2'd1;
                    end
                    2'b11: begin
                        if (fifo_cnt == 2'd1) begin
                            fifo_d0 <= ram_do;
                            fifo_l0 <= push_last;
                        end else begin
                            fifo_d0 <= fifo_d1;
                            fifo_l0 <= fifo_l1;
                            fifo_d1 <= ram_do;
                            fifo_l1 <= push_last;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mesh_unloader.sv
// Bench for mesh_unloader: RAM model, randomized meshes and backpressure,
// expected stream built from the memory layout rules.
module tb_mesh_unloader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] ram_do = '0;
    logic        ram_en;
    logic [10:0] ram_a;
    logic [3:0]  ram_we;
    logic [31:0] ram_di;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic        busy;
    logic        err;
    logic [2:0]  dbg_state;

    mesh_unloader #(.ADDR_WIDTH(11)) dut (
        .clk(clk), .rst(rst), .start(start), .ram_do(ram_do),
        .ram_en(ram_en), .ram_a(ram_a), .ram_we(ram_we), .ram_di(ram_di),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .err(err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:2047];
    always @(posedge clk) if (ram_en) ram_do <= mem[ram_a];

    int n_checks = 0;
    int n_pass = 0;

    logic [31:0] exp_q[$];
    longint      exp_t;
    logic [31:0] got_q[$];
    logic        got_last_q[$];
    int last_xfer_cyc, busy_fall_cyc, err_cnt, err_cyc, hold_err, reads, max_a, max_outst;
    int timed_out, we_bad;
    logic busy_at_err, c1_busy, c1_en;
    logic [10:0] c1_a, c2_a;

    // Reference model: fill RAM with a mesh and derive the expected stream.
    task automatic build_mesh(input longint v, input longint f);
        exp_t = 2 + 3 * v + 4 * f;
        mem[0] = v[31:0];
        mem[1] = f[31:0];
        for (int i = 2; i < 2048; i++) mem[i] = $urandom;
        exp_q.delete();
        if (exp_t <= 2048)
            for (int i = 0; i < exp_t; i++) exp_q.push_back(mem[i]);
    endtask

    // Driver/monitor: pulse start, run until busy falls, record everything seen.
    task automatic run_unload(input int ready_pct, input int restart_at, input int max_cycles);
        logic pstall;
        logic [31:0] pd;
        logic pl;
        got_q.delete();
        got_last_q.delete();
        last_xfer_cyc = -1; busy_fall_cyc = -1; err_cnt = 0; err_cyc = -1;
        hold_err = 0; reads = 0; max_a = -1; max_outst = 0; timed_out = 1; we_bad = 0;
        busy_at_err = 1'b1; c1_busy = 1'b0; c1_en = 1'b0; c1_a = '1; c2_a = '1;
        pstall = 1'b0; pd = '0; pl = 1'b0;
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b0;
        for (int k = 1; k <= max_cycles; k++) begin
            @(negedge clk);
            start = (k == restart_at);
            out_ready = ($urandom_range(1, 100) <= ready_pct);
            #1;
            if (k == 1) begin c1_busy = busy; c1_en = ram_en; c1_a = ram_a; end
            if (k == 2) c2_a = ram_a;
            if (ram_en) begin
                reads++;
                if (int'(ram_a) > max_a) max_a = int'(ram_a);
            end
            if (ram_we != 4'd0 || ram_di != 32'd0) we_bad++;
            if (pstall && (!out_valid || out_data !== pd || out_last !== pl)) hold_err++;
            if (err) begin err_cnt++; err_cyc = k; busy_at_err = busy; end
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                got_last_q.push_back(out_last);
                last_xfer_cyc = k;
            end
            if (reads - got_q.size() > max_outst) max_outst = reads - got_q.size();
            pstall = out_valid && !out_ready;
            pd = out_data;
            pl = out_last;
            if (!busy) begin
                busy_fall_cyc = k;
                timed_out = 0;
                break;
            end
        end
        start = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (ram_en !== 1'b0) $display("FAIL reset_ram_en: got %b want 0", ram_en); else n_pass++;
        n_checks++; if (ram_a !== 11'd0) $display("FAIL reset_ram_a: got %0d want 0", ram_a); else n_pass++;
        n_checks++; if (ram_we !== 4'd0) $display("FAIL reset_ram_we: got %h want 0", ram_we); else n_pass++;
        n_checks++; if (ram_di !== 32'd0) $display("FAIL reset_ram_di: got %h want 0", ram_di); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== 32'd0) $display("FAIL reset_out_data: got %h want 0", out_data); else n_pass++;
        n_checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last: got %b want 0", out_last); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
        n_checks++; if (dbg_state !== 3'd0) $display("FAIL reset_state: got %0d want 0", dbg_state); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_minimal();
        int bad;
        build_mesh(1, 0);
        mem[2] = 32'hA; mem[3] = 32'hB; mem[4] = 32'hC;
        exp_q = '{32'd1, 32'd0, 32'hA, 32'hB, 32'hC};
        run_unload(100, -1, 100);
        bad = 0;
        if (got_q.size() != exp_q.size()) bad = 99;
        else foreach (got_q[i]) if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == 4)) bad++;
        n_checks++; if (timed_out != 0) $display("FAIL min_timeout: busy still high"); else n_pass++;
        n_checks++; if (bad != 0) $display("FAIL min_stream: %0d bad of %0d got, want 5 exact", bad, got_q.size()); else n_pass++;
        n_checks++; if (last_xfer_cyc != 8) $display("FAIL min_latency: last at %0d want 8", last_xfer_cyc); else n_pass++;
        n_checks++; if (busy_fall_cyc != last_xfer_cyc + 1) $display("FAIL min_busy_fall: %0d want %0d", busy_fall_cyc, last_xfer_cyc + 1); else n_pass++;
        n_checks++; if (c1_busy !== 1'b1 || c1_en !== 1'b1 || c1_a !== 11'd0) $display("FAIL min_cycle1: busy=%b en=%b a=%0d want 1 1 0", c1_busy, c1_en, c1_a); else n_pass++;
        n_checks++; if (c2_a !== 11'd1) $display("FAIL min_cycle2: a=%0d want 1", c2_a); else n_pass++;
        n_checks++; if (err_cnt != 0 || we_bad != 0) $display("FAIL min_quiet: err=%0d we_bad=%0d want 0 0", err_cnt, we_bad); else n_pass++;
    endtask

    task automatic test_backpressure();
        int bad;
        build_mesh(4, 2);
        run_unload(50, -1, 400);
        bad = 0;
        if (got_q.size() != 22) bad = 99;
        else foreach (got_q[i]) if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == 21)) bad++;
        n_checks++; if (timed_out != 0) $display("FAIL bp_timeout: busy still high"); else n_pass++;
        n_checks++; if (bad != 0) $display("FAIL bp_stream: %0d bad, got %0d words want 22", bad, got_q.size()); else n_pass++;
        n_checks++; if (hold_err != 0) $display("FAIL bp_hold: %0d unstable stalls want 0", hold_err); else n_pass++;
        n_checks++; if (max_outst > 2) $display("FAIL bp_buffer: %0d outstanding want <=2", max_outst); else n_pass++;
        n_checks++; if (busy_fall_cyc != last_xfer_cyc + 1) $display("FAIL bp_busy_fall: %0d want %0d", busy_fall_cyc, last_xfer_cyc + 1); else n_pass++;
    endtask

    task automatic test_empty();
        build_mesh(0, 0);
        run_unload(100, -1, 50);
        n_checks++;
        if (got_q.size() != 2 || got_q[0] !== 32'd0 || got_q[1] !== 32'd0 || got_last_q[0] !== 1'b0 || got_last_q[1] !== 1'b1)
            $display("FAIL empty_stream: got %0d words want 2 words 0,0 last on second", got_q.size());
        else n_pass++;
        n_checks++; if (max_a != 1 || reads != 2) $display("FAIL empty_reads: max addr %0d reads %0d want 1 and 2", max_a, reads); else n_pass++;
        n_checks++; if (last_xfer_cyc != 5) $display("FAIL empty_latency: last at %0d want 5", last_xfer_cyc); else n_pass++;
    endtask

    task automatic test_overflow();
        longint vs[3] = '{700, 64'hFFFF_FFFF, 1};
        longint fs[3] = '{0, 0, 511};
        for (int c = 0; c < 3; c++) begin
            build_mesh(vs[c], fs[c]);
            run_unload(100, -1, 50);
            n_checks++; if (err_cnt != 1 || err_cyc != 4) $display("FAIL ovf_err[%0d]: pulses %0d at %0d want 1 at 4", c, err_cnt, err_cyc); else n_pass++;
            n_checks++; if (busy_at_err !== 1'b0) $display("FAIL ovf_busy[%0d]: busy %b with err want 0", c, busy_at_err); else n_pass++;
            n_checks++; if (got_q.size() != 0 || reads != 2) $display("FAIL ovf_quiet[%0d]: %0d words %0d reads want 0 and 2", c, got_q.size(), reads); else n_pass++;
        end
    endtask

    task automatic test_exact_fit();
        int bad;
        build_mesh(2, 510);
        run_unload(100, -1, 2200);
        bad = 0;
        if (got_q.size() != 2048) bad = 99;
        else foreach (got_q[i]) if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == 2047)) bad++;
        n_checks++; if (err_cnt != 0 || bad != 0) $display("FAIL fit_stream: err %0d bad %0d words %0d want 0 0 2048", err_cnt, bad, got_q.size()); else n_pass++;
        n_checks++; if (last_xfer_cyc != 2051) $display("FAIL fit_latency: last at %0d want 2051", last_xfer_cyc); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int bad;
        int n;
        build_mesh(4, 2);
        got_q.delete();
        @(negedge clk);
        start = 1'b1;
        n = 0;
        while (got_q.size() < 10 && n < 300) begin
            @(negedge clk);
            start = 1'b0;
            out_ready = ($urandom_range(0, 1) == 1);
            #1;
            if (out_valid && out_ready) got_q.push_back(out_data);
            n++;
        end
        @(negedge clk);
        out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        bad = 0;
        if (got_q.size() != 10) bad = 99;
        else foreach (got_q[i]) if (got_q[i] !== exp_q[i]) bad++;
        n_checks++; if (bad != 0) $display("FAIL rstmid_prefix: %0d bad, %0d words want 10", bad, got_q.size()); else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || ram_en !== 1'b0)
            $display("FAIL rstmid_quiet: valid=%b busy=%b en=%b want 0 0 0", out_valid, busy, ram_en);
        else n_pass++;
        run_unload(60, -1, 400);
        bad = 0;
        if (got_q.size() != 22) bad = 99;
        else foreach (got_q[i]) if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == 21)) bad++;
        n_checks++; if (bad != 0 || timed_out != 0) $display("FAIL rstmid_restart: %0d bad, %0d words want 22", bad, got_q.size()); else n_pass++;
    endtask

    task automatic test_start_while_busy();
        int bad;
        int lasts;
        int extra;
        build_mesh(3, 3);
        run_unload(70, 12, 400);
        bad = 0;
        lasts = 0;
        foreach (got_last_q[i]) if (got_last_q[i]) lasts++;
        if (got_q.size() != 23) bad = 99;
        else foreach (got_q[i]) if (got_q[i] !== exp_q[i]) bad++;
        n_checks++; if (bad != 0) $display("FAIL sbusy_stream: %0d bad, %0d words want 23", bad, got_q.size()); else n_pass++;
        n_checks++; if (lasts != 1 || got_last_q[got_last_q.size()-1] !== 1'b1) $display("FAIL sbusy_last: %0d lasts want 1 on final", lasts); else n_pass++;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (busy) extra++;
        end
        n_checks++; if (extra != 0) $display("FAIL sbusy_relaunch: busy %0d cycles after end want 0", extra); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int bad;
        for (int it = 0; it < 5; it++) begin
            build_mesh(longint'($urandom_range(0, 12)), longint'($urandom_range(0, 12)));
            run_unload($urandom_range(25, 100), -1, 600);
            bad = 0;
            if (got_q.size() != exp_q.size()) bad = 99;
            else foreach (got_q[i]) if (got_q[i] !== exp_q[i] || got_last_q[i] !== (i == exp_q.size() - 1)) bad++;
            n_checks++;
            if (bad != 0 || err_cnt != 0 || timed_out != 0)
                $display("FAIL b2b_stream[%0d]: bad %0d words %0d want %0d err %0d", it, bad, got_q.size(), exp_q.size(), err_cnt);
            else n_pass++;
            n_checks++;
            if (hold_err != 0 || max_outst > 2)
                $display("FAIL b2b_flow[%0d]: hold_err %0d outstanding %0d want 0 and <=2", it, hold_err, max_outst);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_minimal();
        test_backpressure();
        test_empty();
        test_overflow();
        test_exact_fit();
        test_reset_mid();
        test_start_while_busy();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
